mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage_load_align.sv | 37 +++
 rtl/mem_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load opcodes, FSM states and the EX->MEM bus layout for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 107;
    localparam int unsigned MS_TO_WS_BUS_WD = 71;

    typedef enum logic [2:0] {
        LdNone = 3'd0,
        LdLb   = 3'd1,
        LdLbu  = 3'd2,
        LdLh   = 3'd3,
        LdLhu  = 3'd4,
        LdLw   = 3'd5,
        LdLwl  = 3'd6,
        LdLwr  = 3'd7
    } load_op_e;

    // Tracks the single outstanding data-bus request owned by MEM.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBuf,
        StDiscard
    } ms_state_e;

    typedef struct packed {
        logic        ex;
        logic        gr_we;
        logic [4:0]  dest;
        logic [2:0]  load_op;
        logic        req_issued;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake, data-bus response and forwarding signals around the MEM stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_data_ok;
    logic [31:0]                data_rdata;
    logic                       flush;
    logic [4:0]                 MS_dest;
    logic [31:0]                MS_result;
    logic                       ms_load_pending;

    // Environment side: EX, WB, data bus and exception unit.
    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata, flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, MS_dest, MS_result, ms_load_pending
    );

    // MEM stage side.
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_data_ok, data_rdata, flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, MS_dest, MS_result, ms_load_pending
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Little-endian load data alignment, including the unaligned lwl/lwr merges with rt.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    output logic [31:0] result
);

    logic [4:0]  sh_r;
    logic [4:0]  sh_l;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select and extend the addressed byte/halfword, or merge for lwl/lwr.
    always_comb begin
        sh_r    = {addr, 3'b000};
        sh_l    = {~addr, 3'b000};          // 8*(3-a)
        shifted = rdata >> sh_r;
        byte_v  = shifted[7:0];
        half_v  = addr[1] ? rdata[31:16] : rdata[15:0];
        result  = rdata;
        case (load_op)
            LdLb:    result = {{24{byte_v[7]}}, byte_v};
            LdLbu:   result = {24'd0, byte_v};
            LdLh:    result = {{16{half_v[15]}}, half_v};
            LdLhu:   result = {16'd0, half_v};
            LdLwl:   result = (rdata << sh_l) | (rt_value & ~(32'hFFFF_FFFF << sh_l));
            LdLwr:   result = (rdata >> sh_r) | (rt_value & ~(32'hFFFF_FFFF >> sh_r));
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-bus response and aligns load data.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  pipe
);

    ms_state_e   state_q, state_d;
    logic        ms_valid_q;
    es_to_ms_t   ms_bus_q;
    es_to_ms_t   es_bus;
    logic [31:0] buf_q;
    logic        buf_load;
    logic        ready_go;
    logic        allowin;
    logic        capture;
    logic        new_req;
    logic [31:0] ld_data;
    logic [31:0] aligned;
    logic [31:0] result;

    assign es_bus   = es_to_ms_t'(pipe.es_to_ms_bus);
    assign ready_go = !ms_bus_q.req_issued || (state_q == StWait && pipe.data_data_ok) ||
                      (state_q == StBuf);
    assign allowin  = !ms_valid_q || (ready_go && pipe.ws_allowin);
    // Flush wins over capture, so a flushed cycle never starts tracking a new request.
    assign capture  = allowin && !pipe.flush;
    assign new_req  = capture && pipe.es_to_ms_valid && es_bus.req_issued;

    // Stage register, response buffer and FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            ms_valid_q <= 1'b0;
            ms_bus_q   <= '0;
            buf_q      <= '0;
        end else begin
            state_q <= state_d;
            if (pipe.flush) begin
                ms_valid_q <= 1'b0;
            end else if (allowin) begin
                ms_valid_q <= pipe.es_to_ms_valid;
            end
            if (capture && pipe.es_to_ms_valid) begin
                ms_bus_q <= es_bus;
            end
            if (buf_load) begin
                buf_q <= pipe.data_rdata;
            end
        end
    end

    // Next-state logic for the outstanding-request tracker.
    always_comb begin
        state_d  = state_q;
        buf_load = 1'b0;
        case (state_q)
            StIdle: begin
                if (new_req) state_d = StWait;
            end
            StWait: begin
                if (pipe.flush) begin
                    state_d = pipe.data_data_ok ? StIdle : StDiscard;
                end else if (pipe.data_data_ok) begin
                    if (pipe.ws_allowin) begin
                        state_d = new_req ? StWait : StIdle;
                    end else begin
                        state_d  = StBuf;
                        buf_load = 1'b1;
                    end
                end
            end
            StBuf: begin
                if (pipe.flush) begin
                    state_d = StIdle;
                end else if (pipe.ws_allowin) begin
                    state_d = new_req ? StWait : StIdle;
                end
            end
            StDiscard: begin
                // The response arriving now belongs to the flushed request.
                if (pipe.data_data_ok) begin
                    if (new_req || (ms_valid_q && ms_bus_q.req_issued && !pipe.flush)) begin
                        state_d = StWait;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ld_data = (state_q == StBuf) ? buf_q : pipe.data_rdata;

    load_align u_load_align (
        .load_op  (ms_bus_q.load_op),
        .addr     (ms_bus_q.alu_result[1:0]),
        .rdata    (ld_data),
        .rt_value (ms_bus_q.rt_value),
        .result   (aligned)
    );

    // Final result and outputs toward WB and the forwarding network.
    always_comb begin
        result = (ms_bus_q.load_op != LdNone) ? aligned : ms_bus_q.alu_result;
        pipe.ms_allowin      = allowin;
        pipe.ms_to_ws_valid  = ms_valid_q && ready_go && !pipe.flush;
        pipe.ms_to_ws_bus    = {ms_bus_q.ex, ms_bus_q.gr_we, ms_bus_q.dest, result, ms_bus_q.pc};
        pipe.MS_dest         = (ms_valid_q && ms_bus_q.gr_we) ? ms_bus_q.dest : 5'd0;
        pipe.MS_result       = result;
        pipe.ms_load_pending = ms_valid_q && (ms_bus_q.load_op != LdNone) && !ready_go;
    end

endmodule
